cpu7_lsu: RTL and testbench
===========================

Name: cpu7_lsu

Overview:
- Parametrised load/store unit for the next-generation core; replaces the inline MEM-stage load-width muxing with a self-contained unit.
- Accepts one memory op at a time from EX and drives a data bus with a req/ack/err handshake.
- Performs byte-lane alignment for both stores and loads, and sign/zero extension on loads.
- Detects misaligned addresses, bus errors and bus timeouts, and returns a single completion to WB carrying an exception cause when the op fails.

Parameters:
- XLEN, 32: data/address width, 32 or 64 only.
- TIMEOUT, 255: max cycles bus_req may wait for ack/err before an access fault is raised; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EX presents a memory op
- req_ready  out  1  unit can accept an op (state IDLE)
- req_we  in  1  1=store, 0=load
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- req_width  in  2  0=B, 1=H, 2=W, 3=D
- req_signext  in  1  load sign-extend
- req_rd  in  5  load destination register
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and exceptions
- resp_rd  out  5  destination register of the completed op
- resp_we  out  1  completed op was a store
- resp_excp  out  1  op faulted
- resp_cause  out  4  4=load misaligned, 5=load fault, 6=store misaligned, 7=store fault
- resp_badaddr  out  XLEN  faulting address
- busy  out  1  stall request to the pipeline (~req_ready)
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  XLEN  req_addr with the low log2(XLEN/8) bits cleared
- bus_wdata  out  XLEN  lane-shifted store data
- bus_be  out  XLEN/8  byte enables
- bus_ack  in  1  bus completion
- bus_err  in  1  bus error completion
- bus_rdata  in  XLEN  full bus word

Behaviour:
- States: IDLE, BUS, RESP.
- Reset (synchronous): state=IDLE, timeout counter=0, all op registers cleared. Outputs after reset: req_ready=1, busy=0, bus_req=0, bus_be=0, resp_valid=0, resp_excp=0, resp_cause=0, resp_rdata=0, resp_badaddr=0.
- IDLE: req_ready=1. If req_valid is high, register the op and the offset off = addr[log2(XLEN/8)-1:0].
  - Misaligned (H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0) or D when XLEN=32 -> go to RESP with excp=1, cause 4 (load) or 6 (store), badaddr=req_addr. No bus_req is issued.
  - Otherwise -> go to BUS.
- BUS: bus_req=1, with bus_we, bus_addr, bus_wdata and bus_be all driven from registers and stable until completion.
  - bus_be = (width mask: B=1, H=3, W=F, D=FF) << off.
  - bus_wdata = req_wdata << (8*off).
  - bus_err=1 (wins over a simultaneous bus_ack) -> RESP with cause 5/7, badaddr=addr.
  - bus_ack=1 alone -> capture data = (bus_rdata >> 8*off), truncated to width and then sign/zero extended; then go to RESP. The ack may arrive in the first BUS cycle.
  - Counter increments each BUS cycle without ack/err. When counter==TIMEOUT and TIMEOUT!=0 -> RESP with cause 5/7.
- RESP: resp_valid=1 for exactly one cycle, carrying the registered resp_* fields, then go to IDLE. req_ready=0 in this state.
- Latency from accept to resp_valid:
  - misaligned: 1 cycle
  - ack in the first BUS cycle: 2 cycles
  - ack after k wait cycles: 2+k cycles
- bus_ack/bus_err arriving in IDLE or RESP is ignored.
- Reset asserted in any state: the op is dropped, no resp_valid is produced, and bus_req=0 from the next cycle.
- resp_rdata is 0 for stores and for faulted ops. resp_rd is 0 for stores.

Test Plan:
- LW addr 0x100, bus_rdata 0xDEADBEEF, ack in the first BUS cycle -> bus_be=4'hF, bus_addr 0x100; resp_valid 2 cycles after accept, resp_rdata 0xDEADBEEF, resp_excp=0.
- LB signext, addr 0x203, bus_rdata 0x80000000 -> bus_be=4'h8, resp_rdata 0xFFFFFF80. Same op as LBU -> resp_rdata 0x00000080.
- SH addr 0x302, wdata 0x00001234, ack after 3 wait cycles -> bus_be=4'hC, bus_wdata 0x12340000 held stable 4 cycles; resp_valid 5 cycles after accept, resp_we=1.
- LH addr 0x401 -> bus_req never asserted; next cycle resp_excp=1, cause=4, badaddr 0x401. SW addr 0x402 -> cause=6.
- TIMEOUT=4, LW with no ack -> cause=5 after 4 wait cycles. Separately, bus_ack and bus_err together on a SW -> cause=7.
- Reset asserted during BUS -> no resp_valid, req_ready=1 and bus_req=0 the next cycle; a late bus_ack is ignored. XLEN=64: LD addr 0x8 -> bus_be=8'hFF. XLEN=32: width D -> cause 4.

Source files
------------

// File: rtl/cpu7_lsu.sv
// cpu7_lsu: single-outstanding load/store unit with byte-lane alignment, load extension and fault reporting.
module cpu7_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [1:0]        req_width,
    input  logic              req_signext,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_we,
    output logic              resp_excp,
    output logic [3:0]        resp_cause,
    output logic [XLEN-1:0]   resp_badaddr,
    output logic              busy,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_be,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [XLEN-1:0]   bus_rdata
);
    localparam int BEW = XLEN / 8;
    localparam int OFFW = $clog2(BEW);
    localparam logic [31:0] TO = 32'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUS, RESP} stateT;
    stateT state, stateN;

    logic            weR, signextR, respExcpR;
    logic [1:0]      widthR;
    logic [4:0]      rdR;
    logic [3:0]      respCauseR;
    logic [OFFW-1:0] offR;
    logic [BEW-1:0]  beR, beMask;
    logic [31:0]     cnt;
    logic [XLEN-1:0] addrR, busAddrR, wdataR, respRdataR, respBadaddrR;
    logic [XLEN-1:0] shifted, keep, loadData;
    logic            misal, signBit, timedOut, busDone;

    always_comb begin
        misal = (req_width == 2'd1 && req_addr[0]) ||
                (req_width == 2'd2 && req_addr[1:0] != 2'd0) ||
                (req_width == 2'd3 && (req_addr[2:0] != 3'd0 || XLEN == 32));
        beMask = req_width == 2'd0 ? BEW'(1) : req_width == 2'd1 ? BEW'(3) :
                 req_width == 2'd2 ? BEW'(15) : '1;
        shifted = bus_rdata >> {offR, 3'b000};
        keep = widthR == 2'd0 ? XLEN'(8'hFF) : widthR == 2'd1 ? XLEN'(16'hFFFF) :
               widthR == 2'd2 ? XLEN'(32'hFFFF_FFFF) : '1;
        signBit = widthR == 2'd0 ? shifted[7] : widthR == 2'd1 ? shifted[15] :
                  widthR == 2'd2 ? shifted[31] : 1'b0;
        loadData = (shifted & keep) | ((signextR && signBit) ? ~keep : '0);
        timedOut = (TO != 32'd0) && (cnt == TO);
        busDone = bus_err || bus_ack || timedOut;
        stateN = state == IDLE ? (req_valid ? (misal ? RESP : BUS) : IDLE) :
                 state == BUS  ? (busDone ? RESP : BUS) : IDLE;
    end

    always_ff @(posedge clk)
        state <= reset ? IDLE : stateN;

    always_ff @(posedge clk) begin
        if (reset) begin
            weR          <= 1'b0;
            signextR     <= 1'b0;
            widthR       <= '0;
            rdR          <= '0;
            offR         <= '0;
            beR          <= '0;
            cnt          <= '0;
            addrR        <= '0;
            busAddrR     <= '0;
            wdataR       <= '0;
            respRdataR   <= '0;
            respExcpR    <= 1'b0;
            respCauseR   <= '0;
            respBadaddrR <= '0;
        end else if (state == IDLE && req_valid) begin
            weR          <= req_we;
            signextR     <= req_signext;
            widthR       <= req_width;
            rdR          <= req_we ? 5'd0 : req_rd;
            offR         <= req_addr[OFFW-1:0];
            beR          <= beMask << req_addr[OFFW-1:0];
            cnt          <= '0;
            addrR        <= req_addr;
            busAddrR     <= {req_addr[XLEN-1:OFFW], OFFW'(0)};
            wdataR       <= req_wdata << {req_addr[OFFW-1:0], 3'b000};
            respRdataR   <= '0;
            respExcpR    <= misal;
            respCauseR   <= misal ? (req_we ? 4'd6 : 4'd4) : 4'd0;
            respBadaddrR <= misal ? req_addr : '0;
        end else if (state == BUS) begin
            // err outranks ack; a timeout is only declared when neither arrived
            if (bus_err || (!bus_ack && timedOut)) begin
                respExcpR    <= 1'b1;
                respCauseR   <= weR ? 4'd7 : 4'd5;
                respBadaddrR <= addrR;
            end else if (bus_ack) begin
                respRdataR   <= weR ? '0 : loadData;
            end else begin
                cnt          <= cnt + 32'd1;
            end
        end
    end

    assign req_ready    = state == IDLE;
    assign busy         = ~req_ready;
    assign bus_req      = state == BUS;
    assign bus_we       = weR;
    assign bus_addr     = busAddrR;
    assign bus_wdata    = wdataR;
    assign bus_be       = bus_req ? beR : '0;
    assign resp_valid   = state == RESP;
    assign resp_rdata   = respRdataR;
    assign resp_rd      = rdR;
    assign resp_we      = weR;
    assign resp_excp    = respExcpR;
    assign resp_cause   = respCauseR;
    assign resp_badaddr = respBadaddrR;
endmodule

// File: tb/tb_cpu7_lsu.sv
// tb_cpu7_lsu: directed checks of cpu7_lsu at XLEN=32 (TIMEOUT=4) and XLEN=64.
module tb_cpu7_lsu;
    logic clk, reset;
    int checks = 0, failures = 0;

    logic        reqValid, reqReady, reqWe, reqSignext, respValid, respWe, respExcp, busy, busReq, busWe, busAck, busErr;
    logic [31:0] reqAddr, reqWdata, respRdata, respBadaddr, busAddr, busWdata, busRdata;
    logic [1:0]  reqWidth;
    logic [4:0]  reqRd, respRd;
    logic [3:0]  respCause, busBe;

    logic        dReqValid, dReqReady, dReqWe, dReqSignext, dRespValid, dRespWe, dRespExcp, dBusy, dBusReq, dBusWe, dBusAck, dBusErr;
    logic [63:0] dReqAddr, dReqWdata, dRespRdata, dRespBadaddr, dBusAddr, dBusWdata, dBusRdata;
    logic [1:0]  dReqWidth;
    logic [4:0]  dReqRd, dRespRd;
    logic [3:0]  dRespCause;
    logic [7:0]  dBusBe;

    cpu7_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_width(reqWidth), .req_signext(reqSignext),
        .req_rd(reqRd), .resp_valid(respValid), .resp_rdata(respRdata), .resp_rd(respRd),
        .resp_we(respWe), .resp_excp(respExcp), .resp_cause(respCause), .resp_badaddr(respBadaddr),
        .busy(busy), .bus_req(busReq), .bus_we(busWe), .bus_addr(busAddr), .bus_wdata(busWdata),
        .bus_be(busBe), .bus_ack(busAck), .bus_err(busErr), .bus_rdata(busRdata)
    );

    cpu7_lsu #(.XLEN(64), .TIMEOUT(255)) dut64 (
        .clk(clk), .reset(reset), .req_valid(dReqValid), .req_ready(dReqReady), .req_we(dReqWe),
        .req_addr(dReqAddr), .req_wdata(dReqWdata), .req_width(dReqWidth), .req_signext(dReqSignext),
        .req_rd(dReqRd), .resp_valid(dRespValid), .resp_rdata(dRespRdata), .resp_rd(dRespRd),
        .resp_we(dRespWe), .resp_excp(dRespExcp), .resp_cause(dRespCause), .resp_badaddr(dRespBadaddr),
        .busy(dBusy), .bus_req(dBusReq), .bus_we(dBusWe), .bus_addr(dBusAddr), .bus_wdata(dBusWdata),
        .bus_be(dBusBe), .bus_ack(dBusAck), .bus_err(dBusErr), .bus_rdata(dBusRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // presents one op to the 32-bit unit for exactly one accepting cycle
    task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] width, input logic sext, input logic [4:0] rd);
        reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata;
        reqWidth = width; reqSignext = sext; reqRd = rd;
        chk("accept_ready", reqReady, 1);
        tick();
        reqValid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        reqValid = 0; reqWe = 0; reqAddr = 0; reqWdata = 0; reqWidth = 0; reqSignext = 0; reqRd = 0;
        busAck = 0; busErr = 0; busRdata = 0;
        dReqValid = 0; dReqWe = 0; dReqAddr = 0; dReqWdata = 0; dReqWidth = 0; dReqSignext = 0; dReqRd = 0;
        dBusAck = 0; dBusErr = 0; dBusRdata = 0;
        tick();
        tick();
        chk("rst_ready", reqReady, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bus_req", busReq, 0);
        chk("rst_bus_be", busBe, 0);
        chk("rst_resp_valid", respValid, 0);
        chk("rst_resp_excp", respExcp, 0);
        chk("rst_resp_cause", respCause, 0);
        chk("rst_resp_rdata", respRdata, 0);
        chk("rst_resp_badaddr", respBadaddr, 0);
        reset = 1'b0;
        tick();

        present(0, 32'h100, 0, 2'd2, 0, 5'd5);
        busAck = 1; busRdata = 32'hDEADBEEF;
        chk("lw_bus_req", busReq, 1);
        chk("lw_be", busBe, 4'hF);
        chk("lw_addr", busAddr, 32'h100);
        chk("lw_busy", busy, 1);
        tick();
        busAck = 0;
        chk("lw_resp_valid", respValid, 1);
        chk("lw_rdata", respRdata, 32'hDEADBEEF);
        chk("lw_excp", respExcp, 0);
        chk("lw_rd", respRd, 5);
        chk("lw_ready_resp", reqReady, 0);
        tick();
        chk("lw_resp_done", respValid, 0);
        chk("lw_ready_idle", reqReady, 1);

        present(0, 32'h203, 0, 2'd0, 1, 5'd7);
        busAck = 1; busRdata = 32'h8000_0000;
        chk("lb_be", busBe, 4'h8);
        chk("lb_addr", busAddr, 32'h200);
        tick();
        busAck = 0;
        chk("lb_rdata", respRdata, 32'hFFFF_FF80);
        tick();
        present(0, 32'h203, 0, 2'd0, 0, 5'd7);
        busAck = 1;
        tick();
        busAck = 0;
        chk("lbu_rdata", respRdata, 32'h0000_0080);
        tick();

        present(1, 32'h302, 32'h1234, 2'd1, 0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            chk("sh_bus_req", busReq, 1);
            chk("sh_we", busWe, 1);
            chk("sh_be", busBe, 4'hC);
            chk("sh_wdata", busWdata, 32'h1234_0000);
            chk("sh_no_resp", respValid, 0);
            if (i == 3) busAck = 1;
            tick();
        end
        busAck = 0;
        chk("sh_resp_valid", respValid, 1);
        chk("sh_resp_we", respWe, 1);
        chk("sh_resp_rd", respRd, 0);
        chk("sh_rdata", respRdata, 0);
        chk("sh_excp", respExcp, 0);
        tick();

        present(0, 32'h401, 0, 2'd1, 0, 5'd3);
        chk("lh_mis_bus_req", busReq, 0);
        chk("lh_mis_valid", respValid, 1);
        chk("lh_mis_excp", respExcp, 1);
        chk("lh_mis_cause", respCause, 4);
        chk("lh_mis_badaddr", respBadaddr, 32'h401);
        chk("lh_mis_rdata", respRdata, 0);
        tick();
        present(1, 32'h402, 32'hAABBCCDD, 2'd2, 0, 5'd0);
        chk("sw_mis_bus_req", busReq, 0);
        chk("sw_mis_cause", respCause, 6);
        chk("sw_mis_badaddr", respBadaddr, 32'h402);
        tick();

        present(0, 32'h500, 0, 2'd2, 0, 5'd4);
        for (int i = 0; i < 5; i++) begin
            chk("to_bus_req", busReq, 1);
            chk("to_no_resp", respValid, 0);
            tick();
        end
        chk("to_valid", respValid, 1);
        chk("to_excp", respExcp, 1);
        chk("to_cause", respCause, 5);
        chk("to_badaddr", respBadaddr, 32'h500);
        tick();

        present(1, 32'h600, 32'h55, 2'd2, 0, 5'd0);
        busAck = 1; busErr = 1;
        tick();
        busAck = 0; busErr = 0;
        chk("err_valid", respValid, 1);
        chk("err_cause", respCause, 7);
        chk("err_badaddr", respBadaddr, 32'h600);
        chk("err_rdata", respRdata, 0);
        tick();

        present(0, 32'h700, 0, 2'd2, 0, 5'd6);
        chk("rb_bus_req", busReq, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("rb_bus_req_off", busReq, 0);
        chk("rb_ready", reqReady, 1);
        chk("rb_no_resp", respValid, 0);
        busAck = 1; busRdata = 32'h1111_2222;
        tick();
        busAck = 0;
        chk("late_ack_no_resp", respValid, 0);
        chk("late_ack_bus_req", busReq, 0);
        chk("late_ack_ready", reqReady, 1);

        present(0, 32'h800, 0, 2'd3, 0, 5'd1);
        chk("d32_bus_req", busReq, 0);
        chk("d32_valid", respValid, 1);
        chk("d32_cause", respCause, 4);
        tick();

        dReqValid = 1; dReqAddr = 64'h8; dReqWidth = 2'd3; dReqRd = 5'd2;
        chk("ld_ready", dReqReady, 1);
        tick();
        dReqValid = 0;
        chk("ld_bus_req", dBusReq, 1);
        chk("ld_be", dBusBe, 8'hFF);
        chk("ld_addr", dBusAddr, 64'h8);
        dBusAck = 1; dBusRdata = 64'h0123_4567_89AB_CDEF;
        tick();
        dBusAck = 0;
        chk("ld_valid", dRespValid, 1);
        chk("ld_rdata", dRespRdata, 64'h0123_4567_89AB_CDEF);
        tick();
        dReqValid = 1; dReqAddr = 64'hC; dReqWidth = 2'd2; dReqSignext = 1;
        tick();
        dReqValid = 0;
        chk("lw64_be", dBusBe, 8'hF0);
        chk("lw64_addr", dBusAddr, 64'h8);
        dBusAck = 1; dBusRdata = 64'h8000_0000_0000_0000;
        tick();
        dBusAck = 0;
        chk("lw64_rdata", dRespRdata, 64'hFFFF_FFFF_8000_0000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
